mdu_pipe: RTL and testbench
===========================

MDU_PIPE -- requirements
Module: mdu_pipe

Interface
REQ-001 Parameter WIDTH, default 32, is the operand and HI/LO register width.
REQ-002 Parameter MUL_LAT, default 5, is the busy cycles for multiply ops (range 1..31).
REQ-003 Parameter DIV_LAT, default 10, is the busy cycles for divide ops (range 1..31).
REQ-004 Port clk, input, 1: single clock; all state changes on rising edge.
REQ-005 Port reset, input, 1: synchronous, active-low reset.
REQ-006 Port start, input, 1: launch op in the current cycle.
REQ-007 Port op, input, 3: operation code from the shared package.
REQ-008 Port a, input, WIDTH: operand rs.
REQ-009 Port b, input, WIDTH: operand rt.
REQ-010 Port busy, output, 1: operation in flight; the hazard unit stalls D on busy|start for any MDU-class instruction.
REQ-011 Port hi, output, WIDTH: architectural HI register.
REQ-012 Port lo, output, WIDTH: architectural LO register.

Function
REQ-013 Ops: MULT, MULTU, DIV, DIVU, MTHI, MTLO (plus MADD, MADDU per REQ-028).
REQ-014 FSM has two states: IDLE and RUN.
REQ-015 IDLE with start and a mul/div op: latch a, b and op; load counter with the op's LAT; go to RUN.
REQ-016 RUN: decrement counter each cycle; at count==1, commit the result to hi/lo and return to IDLE.
REQ-017 busy is high for exactly LAT consecutive cycles starting the cycle after the start edge; hi/lo hold the new value in the first cycle busy is low.
REQ-018 start while busy is ignored: no state change, no error.
REQ-019 MTHI/MTLO with start in IDLE write a to hi/lo at that edge, never assert busy, and leave the other register unchanged.
REQ-020 MULT/MULTU: {hi,lo} = the full 2*WIDTH product, signed or unsigned respectively.
REQ-021 DIV: lo = quotient truncated toward zero; hi = remainder carrying the dividend's sign.
REQ-022 DIVU: lo = unsigned quotient; hi = unsigned remainder.
REQ-023 Divide by zero: the op still runs DIV_LAT busy cycles; hi/lo stay unchanged.
REQ-024 Signed overflow (min / -1): lo = min, hi = 0.
REQ-025 Undefined op codes with start are ignored, like a no-op.
REQ-026 hi/lo hold their values between commits; operands latched at start are unaffected by later changes on a/b.

Reset
REQ-027 When reset==0 at a clock edge: hi=0, lo=0, busy=0, counter=0, state=IDLE; any in-flight op is aborted with no commit, including mid-RUN.

Configuration
REQ-028 Macro MDU_MADD_EN defined: MADD/MADDU add the signed/unsigned product to {hi,lo} (modulo 2^(2*WIDTH)) with MUL_LAT latency; the accumulator source is {hi,lo} sampled at the start edge.
REQ-029 MDU_MADD_EN undefined: MADD/MADDU codes fall under REQ-025.

Structure
REQ-030 Package mdu_pkg holds the op-code enumeration, the FSM state typedef and the default latency constants.
REQ-031 One sub-module, mdu_arith, holds the combinational product/quotient/remainder for the latched operands; mdu_pipe holds the FSM, counter and hi/lo registers.

Verification
REQ-032 MULT a=0xFFFFFFFD, b=7 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-033 DIVU a=100, b=7 -> busy high 10 cycles, then lo=14, hi=2; DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-034 MTLO a=0x1234 in IDLE -> lo=0x1234 next cycle, busy never high, hi unchanged; start DIV during RUN -> ignored, first result intact.
REQ-035 DIV b=0 with hi=5, lo=9 -> busy 10 cycles, then hi=5, lo=9; DIV a=0x80000000, b=-1 -> lo=0x80000000, hi=0.
REQ-036 Reset low on cycle 3 of a DIV -> next cycle busy=0, hi=lo=0, no later commit.
REQ-037 With MDU_MADD_EN, hi=0, lo=10, MADD a=3, b=4 -> after 5 busy cycles lo=22, hi=0; without the macro -> no busy, hi/lo unchanged.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: op codes, FSM state encoding and default latencies shared by the MDU.
package mdu_pkg;
  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_MADD  = 3'd6,
    OP_MADDU = 3'd7
  } mdu_op_e;
  typedef logic [0:0] state_t;
  localparam state_t S_IDLE = 1'b0;
  localparam state_t S_RUN  = 1'b1;
  localparam int MUL_LAT_DEF = 5;
  localparam int DIV_LAT_DEF = 10;
endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: combinational product/quotient/remainder (and multiply-accumulate) of the latched operands.
module mdu_arith import mdu_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic [2:0]         i_op,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  input  logic [2*WIDTH-1:0] i_acc,
  output logic [WIDTH-1:0]   o_hi,
  output logic [WIDTH-1:0]   o_lo,
  output logic               o_wr
);
  logic [2*WIDTH-1:0] w_sprod, w_uprod;
  logic               w_bz, w_ovf;
  logic [WIDTH-1:0]   w_sden, w_uden, w_uq, w_ur;
  logic signed [WIDTH-1:0] w_sq, w_sr;
  assign w_sprod = $signed({{WIDTH{i_a[WIDTH-1]}}, i_a}) * $signed({{WIDTH{i_b[WIDTH-1]}}, i_b});
  assign w_uprod = {{WIDTH{1'b0}}, i_a} * {{WIDTH{1'b0}}, i_b};
  assign w_bz    = i_b == '0;
  assign w_ovf   = i_a == {1'b1, {(WIDTH-1){1'b0}}} && i_b == '1;
  // min / -1 divides by 1 instead, which yields exactly lo=min, hi=0 without overflow
  assign w_sden  = (w_bz || w_ovf) ? WIDTH'(1) : i_b;
  assign w_uden  = w_bz ? WIDTH'(1) : i_b;
  assign w_sq    = $signed(i_a) / $signed(w_sden);
  assign w_sr    = $signed(i_a) % $signed(w_sden);
  assign w_uq    = i_a / w_uden;
  assign w_ur    = i_a % w_uden;
  assign o_wr    = !((i_op == OP_DIV || i_op == OP_DIVU) && w_bz);
  assign {o_hi, o_lo} = i_op == OP_MULT  ? w_sprod :
                        i_op == OP_MULTU ? w_uprod :
                        i_op == OP_DIV   ? {w_sr, w_sq} :
                        i_op == OP_DIVU  ? {w_ur, w_uq} :
                        i_op == OP_MADD  ? i_acc + w_sprod :
                                           i_acc + w_uprod;
endmodule

// File: rtl/mdu_pipe.sv
// mdu_pipe: multi-cycle multiply/divide unit with HI/LO registers, busy for a fixed latency per op.
// Define MDU_MADD_EN to enable the MADD/MADDU multiply-accumulate ops.
module mdu_pipe import mdu_pkg::*; #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  state_t           r_state;
  logic [4:0]       r_cnt;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a, r_b;
  logic [WIDTH-1:0] w_hi, w_lo;
  logic             w_wr, w_is_mul, w_is_div, w_is_madd, w_launch;
  assign w_is_mul = op == OP_MULT || op == OP_MULTU;
  assign w_is_div = op == OP_DIV || op == OP_DIVU;
`ifdef MDU_MADD_EN
  assign w_is_madd = op == OP_MADD || op == OP_MADDU;
`else
  assign w_is_madd = 1'b0;
`endif
  assign w_launch = start && r_state == S_IDLE && (w_is_mul || w_is_div || w_is_madd);
  assign busy     = r_state == S_RUN;
  // hi/lo cannot change during RUN, so the live registers serve as the start-edge accumulator
  mdu_arith #(.WIDTH(WIDTH)) u_arith (
    .i_op (r_op),
    .i_a  (r_a),
    .i_b  (r_b),
    .i_acc({hi, lo}),
    .o_hi (w_hi),
    .o_lo (w_lo),
    .o_wr (w_wr)
  );
  always_ff @(posedge clk)
    if (w_launch) begin
      r_op <= op;
      r_a  <= a;
      r_b  <= b;
    end
  always_ff @(posedge clk)
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      hi      <= '0;
      lo      <= '0;
    end else if (r_state == S_IDLE) begin
      if (w_launch) begin
        r_state <= S_RUN;
        r_cnt   <= w_is_div ? 5'(DIV_LAT) : 5'(MUL_LAT);
      end
      if (start && op == OP_MTHI) hi <= a;
      if (start && op == OP_MTLO) lo <= a;
    end else if (r_cnt == 5'd1) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      if (w_wr) begin
        hi <= w_hi;
        lo <= w_lo;
      end
    end else
      r_cnt <= r_cnt - 5'd1;
endmodule

// File: tb/tb_mdu_pipe.sv
// tb_mdu_pipe: directed vectors with a queue scoreboard checked whenever busy drops or an immediate result is due.
module tb_mdu_pipe;
  import mdu_pkg::*;
  logic        clk = 0, reset, start;
  logic [2:0]  op;
  logic [31:0] a, b, hi, lo;
  logic        busy;
  int          checks = 0, errors = 0, cyc = 0, runlen = 0;
  typedef struct {
    bit          imm;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
    int          due;
    string       name;
  } item_t;
  item_t q[$];
  item_t it;

  mdu_pipe dut (.clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
                .busy(busy), .hi(hi), .lo(lo));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", n, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (busy === 1'b1) runlen++;
    else if (runlen > 0) begin
      if (q.size() > 0 && !q[0].imm) begin
        it = q.pop_front();
        chk({it.name, "_hi"}, hi, it.hi);
        chk({it.name, "_lo"}, lo, it.lo);
        chk({it.name, "_busy_len"}, 32'(runlen), 32'(it.lat));
      end else begin
        checks++;
        errors++;
        $display("FAIL unexpected_busy: busy ran %0d cycles, expected none", runlen);
      end
      runlen = 0;
    end
    if (q.size() > 0 && q[0].imm && cyc >= q[0].due) begin
      it = q.pop_front();
      chk({it.name, "_hi"}, hi, it.hi);
      chk({it.name, "_lo"}, lo, it.lo);
      chk({it.name, "_busy"}, {31'd0, busy}, 32'd0);
    end
    if (q.size() > 0 && !q[0].imm && cyc > q[0].due) begin
      it = q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s_timeout: busy still %b at cycle %0d, expected drop by %0d", it.name, busy, cyc, it.due);
    end
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                       input bit imm, input logic [31:0] eh, input logic [31:0] el,
                       input int lat, input string nm);
    @(posedge clk); #1;
    start = 1; op = o; a = av; b = bv;
    q.push_back('{imm, eh, el, lat, imm ? cyc + 1 : cyc + lat + 4, nm});
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: %0d results outstanding, expected 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    reset = 0; start = 0; op = 0; a = 0; b = 0;
    repeat (2) @(posedge clk);
    #1 q.push_back('{1, 32'd0, 32'd0, 0, cyc, "reset"});
    @(posedge clk); #1 reset = 1;
    wait_idle();
    issue(OP_MULT,  32'hFFFFFFFD, 32'd7,        0, 32'hFFFFFFFF, 32'hFFFFFFEB, 5,  "mult_neg");
    wait_idle();
    issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'hFFFFFFFE, 32'h00000001, 5,  "multu_max");
    wait_idle();
    issue(OP_DIVU,  32'd100,      32'd7,        0, 32'd2,        32'd14,       10, "divu");
    wait_idle();
    issue(OP_DIV,   32'hFFFFFFF9, 32'd2,        0, 32'hFFFFFFFF, 32'hFFFFFFFD, 10, "div_neg");
    wait_idle();
    issue(OP_MTLO,  32'h1234,     32'd0,        1, 32'hFFFFFFFF, 32'h1234,     0,  "mtlo");
    wait_idle();
    issue(OP_MTHI,  32'd5,        32'd0,        1, 32'd5,        32'h1234,     0,  "mthi");
    issue(OP_MTLO,  32'd9,        32'd0,        1, 32'd5,        32'd9,        0,  "mtlo9");
    wait_idle();
    issue(OP_DIV,   32'd77,       32'd0,        0, 32'd5,        32'd9,        10, "div_zero");
    wait_idle();
    issue(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 0, 32'd0,        32'h80000000, 10, "div_ovf");
    wait_idle();
    // second start mid-RUN and operand changes must not disturb the first op
    issue(OP_MULT,  32'd6,        32'd7,        0, 32'd0,        32'd42,       5,  "mult_ignore");
    a = 32'hDEAD; b = 32'hBEEF;
    @(posedge clk); #1 start = 1; op = OP_DIV; a = 32'd100; b = 32'd7;
    @(posedge clk); #1 start = 0;
    wait_idle();
    issue(OP_MTLO,  32'd10,       32'd0,        1, 32'd0,        32'd10,       0,  "mtlo10");
    wait_idle();
`ifdef MDU_MADD_EN
    issue(OP_MADD,  32'd3,        32'd4,        0, 32'd0,        32'd22,       5,  "madd");
`else
    issue(OP_MADD,  32'd3,        32'd4,        1, 32'd0,        32'd10,       0,  "madd_off");
`endif
    wait_idle();
    issue(OP_MTHI,  32'd3,        32'd0,        1, 32'd3,        32'(lo),      0,  "mthi3");
    wait_idle();
    @(posedge clk); #1 start = 1; op = OP_DIVU; a = 32'd100; b = 32'd7;
    q.push_back('{0, 32'd0, 32'd0, 3, cyc + 8, "div_reset"});
    @(posedge clk); #1 start = 0;
    @(posedge clk);
    @(posedge clk); #1 reset = 0;
    @(posedge clk); #1 reset = 1;
    q.push_back('{1, 32'd0, 32'd0, 0, cyc + 12, "no_late_commit"});
    wait_idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 100000");
    $fatal(1, "watchdog");
  end
endmodule
